ser10_tx: RTL and testbench
===========================

SER10_TX -- requirements
Module: ser10_tx

Interface
REQ-001 Parameter IDLE_WORD, default 10'h000: word shifted out when no data word is available.
REQ-002 Parameter MSB_FIRST, default 0: 0 = bit 0 transmitted first, 1 = bit 9 first.
REQ-003 clk  input  1  fast bit clock; all state on rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 data_i  input  10  parallel word to transmit.
REQ-006 valid_i  input  1  data_i valid.
REQ-007 ready_o  output  1  block accepts data_i this cycle.
REQ-008 bitslip_i  input  1  one-cycle pulse requesting a one-bit frame shift; present only with SER10_TX_BITSLIP_EN.
REQ-009 serial_o  output  1  serial bit stream, one bit per clk cycle.
REQ-010 pclk_o  output  1  word clock, clk/10, 50 % duty, frame-aligned.
REQ-011 underrun_o  output  1  sticky flag: an idle word was inserted after data had started.

Function
REQ-012 The block SHALL contain a bit counter bit_cnt counting 0..9 and wrapping 9->0 every clk cycle.
REQ-013 The block SHALL contain a 10-bit shift register sr with serial_o driven directly by the sr output flop (sr[0], or sr[9] when MSB_FIRST=1), shifting one position per cycle.
REQ-014 The block SHALL contain a one-word holding buffer with full flag; ready_o SHALL equal NOT full.
REQ-015 A transfer SHALL occur on a rising edge with valid_i=1 and ready_o=1; data_i SHALL be written to the buffer, except per REQ-017.
REQ-016 On the edge ending a bit_cnt=9 cycle, sr SHALL load the buffer word when full (clearing full), else IDLE_WORD.
REQ-017 Simultaneous event: with bit_cnt=9, buffer empty and a transfer, data_i SHALL load into sr directly and the buffer SHALL stay empty.
REQ-018 Latency: a word loaded at the end of a bit_cnt=9 cycle SHALL have its first bit on serial_o in the following bit_cnt=0 cycle and its last bit in the bit_cnt=9 cycle.
REQ-019 pclk_o SHALL be a flop that is high during bit_cnt 0..4 and low during bit_cnt 5..9; its rising edge SHALL coincide with the first bit of each word.
REQ-020 underrun_o SHALL set when IDLE_WORD is loaded and at least one transfer has occurred since reset; it SHALL clear only on reset.
REQ-021 A transfer in the cycle bit_cnt=9 with the buffer full SHALL NOT occur, because ready_o=0.

Reset
REQ-022 On rst_n_i=0 the block SHALL asynchronously set bit_cnt=0, sr=IDLE_WORD, full=0, pclk_o=1, underrun_o=0 and the bitslip pending flag=0.
REQ-023 After reset, serial_o SHALL output the first bit of IDLE_WORD and ready_o SHALL be 1.
REQ-024 Reset asserted mid-word SHALL abort the current word and discard buffer contents; the first frame after release SHALL start at bit_cnt=0.

Configuration
REQ-025 With SER10_TX_BITSLIP_EN defined, a bitslip_i pulse SHALL set a pending flag; at the next bit_cnt=9 the counter SHALL hold at 9 for one extra cycle, repeating the last bit, and pclk_o low; the word period SHALL be 11 cycles once, then the flag SHALL clear.
REQ-026 With SER10_TX_BITSLIP_EN defined, bitslip_i pulses while the pending flag is set SHALL be ignored.
REQ-027 Without SER10_TX_BITSLIP_EN, the bitslip_i port and the pending logic SHALL be absent, and the period SHALL always be 10 cycles.

Structure
REQ-028 The shared package ser10_pkg SHALL hold the word width (10), the frame length (10) and the pclk high-phase length (5).
REQ-029 The bit counter with pclk_o generation (and slip when enabled) SHALL be the sub-module ser10_frame_ctr; the buffer and shifter SHALL be in ser10_tx.

Verification
REQ-030 Reset release with no valid_i -> serial_o repeats IDLE_WORD, pclk_o toggles 5 high/5 low, underrun_o=0.
REQ-031 Word 10'h2B5 offered at bit_cnt=9 with buffer empty (bypass) -> serial_o 1,0,1,0,1,1,0,1,0,1 starting next cycle, with pclk_o rising on the first bit.
REQ-032 Back-to-back words 10'h3FF then 10'h001 with valid_i held -> ready_o low while the buffer is full, both words sent contiguously, no idle word between them.
REQ-033 One word sent, then valid_i=0 -> IDLE_WORD follows and underrun_o sets and stays 1.
REQ-034 SER10_TX_BITSLIP_EN with a bitslip_i pulse, and a second pulse 3 cycles later -> exactly one 11-cycle frame, last bit repeated, subsequent frames 10 cycles.
REQ-035 rst_n_i pulsed low at bit_cnt=4 with the buffer full -> outputs take reset values immediately, and the buffered word is never transmitted.

Source files
------------

// File: rtl/ser10_pkg.sv
// ============================================================================
//  ser10_pkg -- shared widths and frame timing for the 10:1 serializer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package ser10_pkg;

    localparam int WORD_W    = 10;
    localparam int FRAME_LEN = 10;
    localparam int PCLK_HIGH = 5;
    localparam int CNT_W     = $clog2(FRAME_LEN);

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam cnt_t LAST_CNT = cnt_t'(FRAME_LEN - 1);

    // Word clock level for the cycle in which the counter holds this value.
    function automatic logic pclk_level(input cnt_t cnt);
        return (cnt < cnt_t'(PCLK_HIGH));
    endfunction

endpackage

`default_nettype wire

// File: rtl/ser10_frame_ctr.sv
// ============================================================================
//  ser10_frame_ctr -- bit counter, word clock and optional one-bit frame slip.
//  Optional feature macro: SER10_TX_BITSLIP_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module ser10_frame_ctr
    import ser10_pkg::*;
(
    input  logic clk,
    input  logic rst_n_i,
`ifdef SER10_TX_BITSLIP_EN
    input  logic bitslip_i,
`endif
    output logic pclk_o,
    output logic frame_end,
    output logic shift_en
);

    cnt_t bit_cnt;
    cnt_t cnt_next;
    logic at_last;
    logic stall;

    assign at_last = (bit_cnt == LAST_CNT);

`ifdef SER10_TX_BITSLIP_EN
    logic slip_pend;
    logic slip_hold;

    // The extra cycle is the first pass through count 9 while a slip is pending.
    assign stall = at_last && slip_pend && !slip_hold;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            slip_pend <= 1'b0;
            slip_hold <= 1'b0;
        end else if (stall) begin
            slip_hold <= 1'b1;
        end else if (slip_hold) begin
            slip_hold <= 1'b0;
            slip_pend <= 1'b0;
        end else if (bitslip_i) begin
            slip_pend <= 1'b1;
        end
    end
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        cnt_next = bit_cnt + cnt_t'(1);
        if (stall) begin
            cnt_next = bit_cnt;
        end else if (at_last) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bit_cnt <= '0;
            pclk_o  <= 1'b1;
        end else begin
            bit_cnt <= cnt_next;
            pclk_o  <= pclk_level(cnt_next);
        end
    end

    assign frame_end = at_last && !stall;
    assign shift_en  = !stall;

endmodule

`default_nettype wire

// File: rtl/ser10_tx.sv
// ============================================================================
//  ser10_tx -- 10-bit parallel to serial transmitter with one-word buffer.
//  Optional feature macro: SER10_TX_BITSLIP_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module ser10_tx
    import ser10_pkg::*;
#(
    parameter word_t IDLE_WORD = 10'h000,
    parameter bit    MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
`ifdef SER10_TX_BITSLIP_EN
    input  logic              bitslip_i,
`endif
    output logic              serial_o,
    output logic              pclk_o,
    output logic              underrun_o
);

    word_t hold_buf;
    word_t sr;
    logic  full;
    logic  started;
    logic  transfer;
    logic  frame_end;
    logic  shift_en;

    ser10_frame_ctr u_frame_ctr (
        .clk       (clk),
        .rst_n_i   (rst_n_i),
`ifdef SER10_TX_BITSLIP_EN
        .bitslip_i (bitslip_i),
`endif
        .pclk_o    (pclk_o),
        .frame_end (frame_end),
        .shift_en  (shift_en)
    );

    assign ready_o  = !full;
    assign transfer = valid_i && ready_o;

    // A transfer on the frame edge bypasses the empty buffer straight into sr.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            full     <= 1'b0;
            hold_buf <= '0;
        end else if (frame_end) begin
            full <= 1'b0;
        end else if (transfer) begin
            full     <= 1'b1;
            hold_buf <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sr <= IDLE_WORD;
        end else if (frame_end) begin
            if (full) begin
                sr <= hold_buf;
            end else if (transfer) begin
                sr <= data_i;
            end else begin
                sr <= IDLE_WORD;
            end
        end else if (shift_en) begin
            if (MSB_FIRST) begin
                sr <= {sr[WORD_W-2:0], 1'b0};
            end else begin
                sr <= {1'b0, sr[WORD_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            started    <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            if (transfer) begin
                started <= 1'b1;
            end
            if (frame_end && !full && !transfer && started) begin
                underrun_o <= 1'b1;
            end
        end
    end

    assign serial_o = MSB_FIRST ? sr[WORD_W-1] : sr[0];

endmodule

`default_nettype wire

// File: tb/tb_ser10_tx.sv
// ============================================================================
//  tb_ser10_tx -- directed and random stimulus against a queue-based model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ser10_tx;

    localparam logic [9:0] IDLE = 10'h000;
    localparam bit         MSBF = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n_i;
    logic [9:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic       serial_o;
    logic       pclk_o;
    logic       underrun_o;
`ifdef SER10_TX_BITSLIP_EN
    logic       bitslip_i;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ser10_tx #(.IDLE_WORD(IDLE), .MSB_FIRST(MSBF)) dut (
        .clk        (clk),
        .rst_n_i    (rst_n_i),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
`ifdef SER10_TX_BITSLIP_EN
        .bitslip_i  (bitslip_i),
`endif
        .serial_o   (serial_o),
        .pclk_o     (pclk_o),
        .underrun_o (underrun_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: 1-deep queue + frame position ----
    logic [9:0] m_cur;
    logic [9:0] m_q[$];
    int         m_pos;
    bit         m_started, m_underrun, m_xfer, m_taken;
    bit         m_pend, m_ext, m_slip_req;

    always @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_cur = IDLE; m_pos = 0; m_q.delete();
            m_started = 0; m_underrun = 0; m_pend = 0; m_ext = 0;
        end else begin
            m_xfer  = valid_i && (m_q.size() == 0);
            m_taken = 0;
`ifdef SER10_TX_BITSLIP_EN
            m_slip_req = bitslip_i && !m_pend;
            if (m_pos == 9 && m_pend && !m_ext) begin
                m_ext = 1;
                m_pos = 10;
            end else
`endif
            if (m_pos >= 9) begin
                m_pos = 0;
                m_pend = 0;
                m_ext = 0;
                if (m_q.size() != 0) begin
                    m_cur = m_q.pop_front();
                end else if (m_xfer) begin
                    m_cur = data_i;
                    m_taken = 1;
                end else begin
                    m_cur = IDLE;
                    if (m_started) m_underrun = 1;
                end
            end else begin
                m_pos++;
            end
            if (m_xfer && !m_taken) m_q.push_back(data_i);
            if (m_xfer) m_started = 1;
`ifdef SER10_TX_BITSLIP_EN
            if (m_slip_req) m_pend = 1;
`endif
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        int bi;
        bi = (m_pos > 9) ? 9 : m_pos;
        check("serial", serial_o, m_cur[MSBF ? 9 - bi : bi]);
        check("pclk", pclk_o, (m_pos < 5));
        check("ready", ready_o, (m_q.size() == 0));
        check("underrun", underrun_o, m_underrun);
    end

    // pclk rising-edge timestamps in cycles
    int  ncyc = 0;
    int  rise_cyc[$];
    bit  pclk_prev = 1'b1;
    always @(negedge clk) begin
        ncyc++;
        if (pclk_o && !pclk_prev) rise_cyc.push_back(ncyc);
        pclk_prev = pclk_o;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int seq [10] = '{1, 0, 1, 0, 1, 1, 0, 1, 0, 1};

    initial begin
        int dens;
        rst_n_i = 1'b0; valid_i = 1'b0; data_i = '0;
`ifdef SER10_TX_BITSLIP_EN
        bitslip_i = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_ready", ready_o, 1);
        check("rst_pclk", pclk_o, 1);
        check("rst_serial", serial_o, IDLE[0]);
        check("rst_underrun", underrun_o, 0);
        #2 rst_n_i = 1'b1;

        // Idle after release, then a bypass word offered in the bit_cnt=9 cycle
        for (int k = 1; k <= 29; k++) begin
            @(negedge clk);
            if (k <= 20) begin
                check("idle_pclk", pclk_o, ((k % 10) < 5));
                check("idle_serial", serial_o, 0);
                check("idle_underrun", underrun_o, 0);
            end
            if (k == 29) begin
                check("pre_rise_pclk", pclk_o, 0);
                #2 valid_i = 1'b1; data_i = 10'h2B5;
            end
        end

        // 2B5 bypass, then 3FF and 001 back-to-back, then idle
        for (int k = 30; k <= 73; k++) begin
            @(negedge clk);
            if (k < 40) check("bypass_bit", serial_o, seq[k-30]);
            if (k == 30) begin
                check("bypass_pclk", pclk_o, 1);
                check("bypass_ready", ready_o, 1);
            end
            if (k == 34) check("full_ready", ready_o, 0);
            if (k == 40) check("drain_ready", ready_o, 1);
            if (k == 41) check("refull_ready", ready_o, 0);
            if (k >= 40 && k < 50) check("w3ff_bit", serial_o, 1);
            if (k == 50) check("w001_b0", serial_o, 1);
            if (k > 50 && k < 60) check("w001_bit", serial_o, 0);
            if (k == 59) check("pre_underrun", underrun_o, 0);
            if (k >= 60) check("underrun_sticky", underrun_o, 1);
            if (k == 72) check("buf_full", ready_o, 0);
            #2;
            if (k == 30) valid_i = 1'b0;
            if (k == 33) begin valid_i = 1'b1; data_i = 10'h3FF; end
            if (k == 34) data_i = 10'h001;
            if (k == 41) valid_i = 1'b0;
            if (k == 71) begin valid_i = 1'b1; data_i = 10'h155; end
            if (k == 72) valid_i = 1'b0;
        end

        // Reset in the bit_cnt=4 cycle with the buffer full
        @(negedge clk);
        #2 rst_n_i = 1'b0;
        #1;
        check("midrst_ready", ready_o, 1);
        check("midrst_pclk", pclk_o, 1);
        check("midrst_serial", serial_o, 0);
        check("midrst_underrun", underrun_o, 0);
        repeat (2) @(negedge clk);
        #2 rst_n_i = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            check("postrst_serial", serial_o, 0);
            check("postrst_underrun", underrun_o, 0);
        end

`ifdef SER10_TX_BITSLIP_EN
        begin
            int base, t;
            base = rise_cyc.size();
            t = 0;
            while (rise_cyc.size() == base && t < 30) begin @(negedge clk); t++; end
            check("slip_rise_seen", (rise_cyc.size() > base), 1);
            base = rise_cyc.size() - 1;
            #2 bitslip_i = 1'b1;
            @(negedge clk); #2 bitslip_i = 1'b0;
            @(negedge clk);
            @(negedge clk); #2 bitslip_i = 1'b1;
            @(negedge clk); #2 bitslip_i = 1'b0;
            t = 0;
            while (rise_cyc.size() < base + 4 && t < 60) begin @(negedge clk); t++; end
            check("slip_rises", (rise_cyc.size() >= base + 4), 1);
            if (rise_cyc.size() >= base + 4) begin
                check("slip_period0", rise_cyc[base+1] - rise_cyc[base], 11);
                check("slip_period1", rise_cyc[base+2] - rise_cyc[base+1], 10);
                check("slip_period2", rise_cyc[base+3] - rise_cyc[base+2], 10);
            end
        end
`endif

        // Random traffic with varying density and rare resets
        dens = 70;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #2;
            if (i % 200 == 0) dens = $urandom_range(0, 100);
            rst_n_i = ($urandom_range(0, 499) != 0);
            valid_i = ($urandom_range(0, 99) < dens);
            data_i  = 10'($urandom);
`ifdef SER10_TX_BITSLIP_EN
            bitslip_i = ($urandom_range(0, 24) == 0);
`endif
        end
        @(negedge clk);
        #2 rst_n_i = 1'b1; valid_i = 1'b0;
        repeat (30) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
